// File: rtl/i2s_rx.sv
// I2S master receiver: generates sck/ws from clk, captures sd and hands out stereo frames.
// Define I2S_RX_OVERRUN_EN to build the sticky overrun flag; otherwise overrun is tied to 0.

module i2s_rx #(
  parameter int unsigned DAT_WDTH = 24,
  parameter int unsigned WS_RATE  = 48000,
  parameter int unsigned SCK_RATE = 3072000,
  parameter int unsigned CLK_RATE = 12288000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                sck,
  output logic                ws,
  input  logic                sd,
  output logic [DAT_WDTH-1:0] left_chan,
  output logic [DAT_WDTH-1:0] right_chan,
  output logic                valid,
  input  logic                ready,
  output logic                overrun
);

  localparam int unsigned SLOT = SCK_RATE / WS_RATE / 2;
  localparam int unsigned HALF = CLK_RATE / SCK_RATE / 2;
  localparam int unsigned SCW  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned SLW  = (SLOT > 1) ? $clog2(SLOT) : 1;

  localparam logic [SCW-1:0] SckReload = SCW'(HALF - 1);
  localparam logic [SLW-1:0] WsReload  = SLW'(SLOT - 1);

  logic [SCW-1:0]      sck_cnt_q, sck_cnt_d;
  logic                sck_q, sck_d;
  logic [SLW-1:0]      ws_cnt_q, ws_cnt_d;
  logic                ws_q, ws_d;
  logic [SLW-1:0]      edge_q, edge_d;
  logic [DAT_WDTH-1:0] sr_l_q, sr_l_d;
  logic [DAT_WDTH-1:0] sr_r_q, sr_r_d;
  logic                primed_q, primed_d;
  logic [DAT_WDTH-1:0] left_q, left_d;
  logic [DAT_WDTH-1:0] right_q, right_d;
  logic                valid_q, valid_d;

  logic rise_evt, fall_evt, ws_flip, boundary, capture;

  assign rise_evt = (sck_cnt_q == '0) && !sck_q;
  assign fall_evt = (sck_cnt_q == '0) && sck_q;
  assign ws_flip  = fall_evt && (ws_cnt_q == '0);
  assign boundary = ws_flip && ws_q;
  // One-bit I2S delay: edge 0 and padding edges past the sample width are dropped.
  assign capture  = rise_evt && (edge_q != '0) && (edge_q <= SLW'(DAT_WDTH));

  always_comb begin
    sck_cnt_d = sck_cnt_q;
    sck_d     = sck_q;
    ws_cnt_d  = ws_cnt_q;
    ws_d      = ws_q;
    edge_d    = edge_q;
    sr_l_d    = sr_l_q;
    sr_r_d    = sr_r_q;
    primed_d  = primed_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = valid_q;

    if (sck_cnt_q == '0) begin
      sck_cnt_d = SckReload;
      sck_d     = !sck_q;
    end else begin
      sck_cnt_d = sck_cnt_q - SCW'(1);
    end

    if (fall_evt) begin
      if (ws_cnt_q == '0) begin
        ws_cnt_d = WsReload;
        ws_d     = !ws_q;
        edge_d   = '0;
      end else begin
        ws_cnt_d = ws_cnt_q - SLW'(1);
      end
    end

    if (rise_evt) begin
      edge_d = edge_q + SLW'(1);
    end

    if (capture) begin
      if (ws_q) begin
        sr_r_d = (sr_r_q << 1) | DAT_WDTH'(sd);
      end else begin
        sr_l_d = (sr_l_q << 1) | DAT_WDTH'(sd);
      end
    end

    // The first boundary after reset only arms delivery; its frame is discarded.
    if (boundary) begin
      primed_d = 1'b1;
    end

    if (boundary && primed_q) begin
      left_d  = sr_l_q;
      right_d = sr_r_q;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_cnt_q <= '0;
      sck_q     <= 1'b0;
      ws_cnt_q  <= WsReload;
      ws_q      <= 1'b0;
      edge_q    <= '0;
      sr_l_q    <= '0;
      sr_r_q    <= '0;
      primed_q  <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      sck_cnt_q <= sck_cnt_d;
      sck_q     <= sck_d;
      ws_cnt_q  <= ws_cnt_d;
      ws_q      <= ws_d;
      edge_q    <= edge_d;
      sr_l_q    <= sr_l_d;
      sr_r_q    <= sr_r_d;
      primed_q  <= primed_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
    end
  end

`ifdef I2S_RX_OVERRUN_EN
  logic overrun_q;

  // A delivered frame replaced before the consumer took it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (boundary && primed_q && valid_q && !ready) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign sck        = sck_q;
  assign ws         = ws_q;
  assign left_chan  = left_q;
  assign right_chan = right_q;
  assign valid      = valid_q;

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter DAT_WDTH, default 24, meaning sample width per channel.
REQ-002 SHALL have parameter WS_RATE, default 48000, meaning frame (sample) rate in Hz.
REQ-003 SHALL have parameter SCK_RATE, default 3072000, meaning bit clock rate in Hz.
REQ-004 SHALL have parameter CLK_RATE, default 12288000, meaning system clock rate in Hz.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port sck, output, 1 bit: generated I2S bit clock (master).
REQ-008 SHALL have port ws, output, 1 bit: generated word select; 0 = left slot, 1 = right slot.
REQ-009 SHALL have port sd, input, 1 bit: serial data from an external I2S transmitter.
REQ-010 SHALL have port left_chan, output, DAT_WDTH bits: received left sample.
REQ-011 SHALL have port right_chan, output, DAT_WDTH bits: received right sample.
REQ-012 SHALL have port valid, output, 1 bit: left_chan/right_chan hold an unconsumed frame.
REQ-013 SHALL have port ready, input, 1 bit: consumer accepts the frame when valid && ready.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag indicating a lost frame.

Function
REQ-015 Definitions: SLOT = SCK_RATE/WS_RATE/2; HALF = CLK_RATE/SCK_RATE/2. Defaults give SLOT = 32 and HALF = 2.
REQ-016 Legal parameters: HALF >= 1 and 1 <= DAT_WDTH <= SLOT-1.
REQ-017 sck SHALL toggle every HALF clk cycles via a down-counter reloaded with HALF-1. A rise event is the cycle where sck goes 0->1; a fall event is the cycle where sck goes 1->0.
REQ-018 ws SHALL change only on a fall event, after every SLOT fall events, via a counter reloaded with SLOT-1.
REQ-019 sd SHALL be sampled on each rise event. Edge index n = 0..SLOT-1 counts rise events since the last ws change.
REQ-020 Bit capture follows I2S one-bit delay: edges n = 1..DAT_WDTH carry the current slot's channel, MSB first. Edge n = 0 and edges n > DAT_WDTH SHALL be ignored.
REQ-021 Captured bits SHALL shift into a left shift register when ws = 0 and a right shift register when ws = 1.
REQ-022 On a fall event where ws changes 1->0 (frame boundary), both shift registers SHALL be copied to left_chan/right_chan, and valid SHALL be 1 from the next cycle.
REQ-023 The copy in REQ-022 SHALL occur only if the frame is primed. A frame is primed when a full ws 0->1 and 1->0 pair has occurred since reset. The first boundary after reset SHALL be discarded, leaving valid = 0.
REQ-024 Handshake: valid && ready SHALL clear valid on the next cycle. left_chan/right_chan SHALL be stable while valid && !ready, except as stated in REQ-025.
REQ-025 Frame boundary while valid && !ready: the new frame SHALL overwrite left_chan/right_chan, valid SHALL stay 1, and overrun SHALL be set.
REQ-026 Frame boundary in the same cycle as valid && ready: the new frame SHALL load, valid SHALL stay 1, and overrun SHALL not be set.
REQ-027 overrun SHALL remain 1 until reset.

Reset
REQ-028 While rst_n = 0, the following SHALL all be 0: sck, ws, valid, overrun, left_chan, right_chan, both shift registers, the primed flag, the edge index, and the sck counter.
REQ-029 While rst_n = 0, the ws counter SHALL be SLOT-1.
REQ-030 Reset asserted mid-frame SHALL abandon the partial frame without delivering it. Operation SHALL restart per REQ-023 after release.

Configuration
REQ-031 Macro I2S_RX_OVERRUN_EN defined: overrun SHALL behave per REQ-025 through REQ-027.
REQ-032 Macro I2S_RX_OVERRUN_EN undefined: the overrun port SHALL exist and be tied to 0, with no flag logic. Overwrite behaviour SHALL remain per REQ-025.

Verification (defaults)
REQ-033 Release rst_n with sd = 0 and ready = 1 -> sck period 4 clk, ws period 256 clk, valid = 0 through the first ws 1->0 transition.
REQ-034 A transmitter model drives left = 24'hA5A5A5 and right = 24'h5A5A5A with ready = 1 -> from the second frame boundary on, valid pulses 1 cycle per frame, with left_chan = A5A5A5 and right_chan = 5A5A5A.
REQ-035 Hold ready = 0 across 3 frames of left = 1, 2, 3 -> valid stays 1, left_chan = 3, and overrun = 1 (macro defined) or 0 (macro undefined).
REQ-036 Pulse ready in the exact cycle of a frame boundary -> valid stays 1, the new data is loaded, and overrun = 0.
REQ-037 Assert rst_n = 0 mid right slot -> all outputs become 0 immediately. After release, the first boundary is discarded and the second delivers a correct frame.
REQ-038 Drive right = 24'hFFFFFF with sd = 1 on ignored edges (n = 0 and padding) -> captured values are unaffected by the padding bits.
